// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR flag bank arbiter: command opcodes and
// the round-robin grant picker.
package sr_ctrl_pkg;

  // Opcode encoding is {s,r}
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_TGL = 2'b11;
  localparam logic [1:0] OP_BAD = 2'b00;

  // Widest requester vector the picker handles
  localparam int RR_MAX = 32;

  // Returns a one-hot grant: the first set bit of req at or after ptr,
  // wrapping within nreq entries; zero when req is empty.
  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0] req,
    input int                nreq,
    input int                ptr
  );
    logic [RR_MAX-1:0] grant;
    logic              found;
    int                cand;
    logic [4:0]        sel;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      cand = ptr + k;
      if (cand >= nreq) cand = cand - nreq;
      sel = cand[4:0];
      if (k < nreq && !found) begin
        if (req[sel]) begin
          grant[sel] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR flip-flop of the flag bank: set dominates clear, reset dominates both.
module sr_cell
  import sr_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qn
);

  logic q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= 1'b0;
    end else if (s) begin
      q_reg <= 1'b1;
    end else if (r) begin
      q_reg <= 1'b0;
    end
  end

  // The decoder upstream must never request set and clear together
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(s && r));
    end
  end

  assign q  = q_reg;
  assign qn = ~q_reg;

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter that registers one set/clear/toggle command per cycle
// and decodes it into per-bit s/r strobes for a bank of SR flip-flops.
module sr_bank_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int NBITS = 8,
  localparam int IDXW  = $clog2(NBITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NBITS-1:0]     q,
  output logic [NBITS-1:0]     qn,
  output logic                 err
);

  localparam int PTRW = $clog2(NREQ);

  logic [PTRW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [NREQ-1:0]  grant;
  logic             grant_any;
  logic [PTRW-1:0]  win;
  logic [1:0]       win_op;
  logic [IDXW-1:0]  win_idx;

  logic             cmd_valid_reg;
  logic [1:0]       cmd_op_reg;
  logic [IDXW-1:0]  cmd_idx_reg;
  logic             cmd_legal;
  logic             err_reg;

  logic [NBITS-1:0] s_vec;
  logic [NBITS-1:0] r_vec;

  // Arbitration and winner mux; nothing is granted while reset is held
  always_comb begin
    int wi;
    grant = '0;
    if (rst_n) begin
      grant = NREQ'(rr_pick(RR_MAX'(req_valid), NREQ, int'(rr_ptr_reg)));
    end
    win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) win = PTRW'(i);
    end
    grant_any = |grant;
    wi        = int'(win);
    win_op    = req_op[2*wi +: 2];
    win_idx   = req_idx[IDXW*wi +: IDXW];
    rr_ptr_next = rr_ptr_reg;
    if (grant_any) begin
      rr_ptr_next = (int'(win) == NREQ-1) ? '0 : win + PTRW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_op_reg    <= OP_BAD;
      cmd_idx_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      cmd_valid_reg <= grant_any;
      if (grant_any) begin
        cmd_op_reg  <= win_op;
        cmd_idx_reg <= win_idx;
      end
      err_reg <= cmd_valid_reg && !cmd_legal;
    end
  end

  // Out-of-range indices are only reachable when NBITS is not a power of two
  assign cmd_legal = (cmd_op_reg != OP_BAD) && (int'(cmd_idx_reg) < NBITS);

  generate
    for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
      logic hit;
      assign hit = cmd_valid_reg && cmd_legal && (int'(cmd_idx_reg) == gi);
      // Toggle reads the live bank bit, so back-to-back toggles chain
      assign s_vec[gi] = hit && ((cmd_op_reg == OP_SET) || ((cmd_op_reg == OP_TGL) && !q[gi]));
      assign r_vec[gi] = hit && ((cmd_op_reg == OP_CLR) || ((cmd_op_reg == OP_TGL) &&  q[gi]));

      sr_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s_vec[gi]),
        .r     (r_vec[gi]),
        .q     (q[gi]),
        .qn    (qn[gi])
      );
    end
  endgenerate

  assign req_ready = grant;
  assign err       = err_reg;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Directed bench for sr_bank_arbiter; a second NBITS=6 instance shares the
// stimulus so out-of-range indices can be exercised.
module tb_sr_bank_arbiter;
  import sr_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [11:0] req_idx;
  logic [3:0]  req_ready;
  logic [7:0]  q, qn;
  logic        err;
  logic [3:0]  req_ready6;
  logic [5:0]  q6, qn6;
  logic        err6;

  int checks = 0;
  int errors = 0;

  sr_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready), .q(q), .qn(qn), .err(err)
  );

  sr_bank_arbiter #(.NREQ(4), .NBITS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready6), .q(q6), .qn(qn6), .err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [2:0] idx);
    req_valid[i]      = v;
    req_op[2*i +: 2]  = op;
    req_idx[3*i +: 3] = idx;
  endtask

  initial begin
    // 1: reset with every requester valid
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, OP_SET, 3'(i));
    tick();
    tick();
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_qn", 32'(qn), 32'hFF);
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    #1;

    // 3: all four valid continuously, grants walk 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
    end
    $display("rr sequence done, q=%0h", q);
    req_valid = 4'h0;
    #1;
    chk("idle_ready", 32'(req_ready), 32'h0);
    tick();
    chk("rr_q", 32'(q), 32'h0F);
    chk("rr_err", 32'(err), 32'h0);

    // 2: single set then clear from req1 (pointer now at 1)
    set_req(1, 1'b1, OP_SET, 3'd5);
    #1;
    chk("set_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'h0;
    chk("set_latency_q", 32'(q), 32'h0F);
    tick();
    chk("set_q", 32'(q), 32'h2F);
    chk("set_qn", 32'(qn), 32'hD0);
    set_req(1, 1'b1, OP_CLR, 3'd5);
    #1;
    chk("clr_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'h0;
    tick();
    chk("clr_q", 32'(q), 32'h0F);
    $display("set/clear idx5 done, q=%0h", q);

    // Plain reset to start the toggle chain from zero
    rst_n = 1'b0;
    tick();
    chk("rst2_q", 32'(q), 32'h00);
    rst_n = 1'b1;

    // 4: req2 toggles idx 3 on three consecutive cycles
    set_req(2, 1'b1, OP_TGL, 3'd3);
    #1;
    chk("tgl_ready0", 32'(req_ready), 32'h4);
    tick();
    chk("tgl_q0", 32'(q), 32'h00);
    chk("tgl_s0", 32'(dut.s_vec), 32'h08);
    chk("tgl_r0", 32'(dut.r_vec), 32'h00);
    chk("tgl_ready1", 32'(req_ready), 32'h4);
    tick();
    chk("tgl_q1", 32'(q), 32'h08);
    chk("tgl_s1", 32'(dut.s_vec), 32'h00);
    chk("tgl_r1", 32'(dut.r_vec), 32'h08);
    tick();
    chk("tgl_q2", 32'(q), 32'h00);
    chk("tgl_sr2", 32'(dut.s_vec & dut.r_vec), 32'h00);
    req_valid = 4'h0;
    tick();
    chk("tgl_q3", 32'(q), 32'h08);
    chk("tgl_sr3", 32'(dut.s_vec | dut.r_vec), 32'h00);
    $display("toggle chain done, q=%0h", q);

    // 5a: illegal opcode from req0 (pointer at 3, so search wraps to 0)
    set_req(0, 1'b1, OP_BAD, 3'd2);
    #1;
    chk("bad_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'h0;
    chk("bad_err_early", 32'(err), 32'h0);
    tick();
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_err6", 32'(err6), 32'h1);
    chk("bad_q", 32'(q), 32'h08);
    chk("bad_q6", 32'(q6), 32'h08);
    tick();
    chk("bad_err_pulse", 32'(err), 32'h0);

    // 5b: set idx 6 is legal for 8 bits, out of range for the 6-bit bank
    set_req(1, 1'b1, OP_SET, 3'd6);
    #1;
    chk("oor_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'h0;
    tick();
    chk("oor_q", 32'(q), 32'h48);
    chk("oor_err", 32'(err), 32'h0);
    chk("oor_err6", 32'(err6), 32'h1);
    chk("oor_q6", 32'(q6), 32'h08);
    tick();
    chk("oor_err6_pulse", 32'(err6), 32'h0);
    req_valid = 4'hF;
    #1;
    chk("ptr_after_bad", 32'(req_ready), 32'h4);
    req_valid = 4'h0;
    #1;
    chk("ptr_idle", 32'(req_ready), 32'h0);
    $display("illegal ops done, q=%0h q6=%0h", q, q6);

    // 6: set idx 7 accepted, then reset on the following edge
    set_req(3, 1'b1, OP_SET, 3'd7);
    #1;
    chk("mid_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'h0;
    rst_n = 1'b0;
    #1;
    chk("mid_ready_rst", 32'(req_ready), 32'h0);
    tick();
    chk("mid_q", 32'(q), 32'h00);
    chk("mid_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("mid_q_after", 32'(q), 32'h00);
    chk("mid_err_after", 32'(err), 32'h0);
    $display("reset mid-operation done, q=%0h", q);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
